serial_frame_tx: RTL and testbench
==================================

# serial_frame_tx

Parallel-to-serial frame transmitter: accepts a `DATA_W`-bit word over a valid/ready handshake and shifts it out on a single registered line as start bit, data LSB-first, optional even parity, and stop bit. Each bit is held for `CLKS_PER_BIT` clock cycles. It is the driving end of the serial D-line that our flip-flop-based capture registers sample, and serves as the stimulus source for those receive chains.

## Interface

- `DATA_W`, default 8: payload width in bits; must be ≥ 1.
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit; must be ≥ 1.
- `PARITY_EN`, default 1: 1 inserts an even-parity bit after the data; 0 omits it.

Ports:

- `clk` input 1: single clock, rising-edge active.
- `rst` input 1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `data_in` input `DATA_W`: word to send; sampled only on accept.
- `valid_in` input 1: `data_in` is valid.
- `ready_out` output 1: block can accept; combinational, equals state==IDLE.
- `tx` output 1: serial line, registered; idles high.
- `busy` output 1: registered; high in every state except IDLE.
- `done` output 1: registered one-cycle pulse at frame completion.

## Operation

- States: IDLE, START, DATA, PARITY, STOP.
- Accept occurs at a rising edge where `valid_in`=1 and `ready_out`=1.
  - On accept, `data_in` is latched into a shift register.
  - The bit-cycle counter and bit index are cleared.
  - State goes to START.
- IDLE: `tx`=1, `busy`=0. `data_in` and `valid_in` are ignored unless accepted.
- START: `tx`=0 for `CLKS_PER_BIT` cycles, then DATA.
- DATA: `tx` = shift register bit 0. After each `CLKS_PER_BIT` cycles, shift right and increment the bit index.
  - After `DATA_W` bits, go to PARITY if `PARITY_EN`=1, else STOP.
- PARITY: `tx` = XOR of all latched data bits (even parity), held for `CLKS_PER_BIT` cycles, then STOP.
- STOP: `tx`=1 for `CLKS_PER_BIT` cycles, then IDLE with `done`=1 for exactly that one cycle.
- Arithmetic and width rules:
  - Bit-cycle counter is `$clog2(CLKS_PER_BIT)` bits wide (minimum 1) and counts 0..`CLKS_PER_BIT`-1.
  - Bit index is `$clog2(DATA_W)` bits wide (minimum 1) and never wraps mid-frame.
- Changes to `data_in` or `valid_in` while `busy`=1 have no effect. No queuing; the upstream must hold `valid_in` until accepted.
- Reset:
  - At an edge with `rst`=1: state=IDLE, `tx`=1, `busy`=0, `done`=0, counters and shift register cleared.
  - Reset mid-frame aborts the frame. `tx` returns high on the next cycle and no `done` is issued.
  - `rst` and `valid_in` at the same edge: reset wins and the word is not accepted.

## Timing

- Let accept occur at edge E0. Define F = (2 + `DATA_W` + `PARITY_EN`) × `CLKS_PER_BIT`.
- Serial line:
  - `tx` goes low after E0.
  - Data bit k appears after edge E0 + (1+k)·`CLKS_PER_BIT`.
  - The parity bit, if enabled, appears after E0 + (1+`DATA_W`)·`CLKS_PER_BIT`.
  - The stop bit begins at E0 + F − `CLKS_PER_BIT`.
- Status signals:
  - `busy` is high from E0 to E0+F.
  - At E0+F, state=IDLE and `done`=1 for one cycle, deasserting at E0+F+1.
- Back-to-back frames:
  - `ready_out` is high from E0+F, so the earliest next accept is at edge E0+F+1 when `valid_in` is held.
  - The minimum frame period is F+1 cycles.
  - `tx` stays high during the single idle cycle between frames.
- Defaults (8, 4, 1): F=44 and the frame period is 45 cycles.
- `tx` has no combinational path from any input.

## Test plan

- **Reset values:** hold `rst`=1 for 3 cycles → `tx`=1, `busy`=0, `done`=0, `ready_out`=1.
- **Single frame, defaults:**
  - Stimulus: send 0xA5.
  - `tx` sequence per 4-cycle bit is 0 | 1,0,1,0,0,1,0,1 | 0 (parity) | 1.
  - `done` pulses at E0+44, `busy` falls at E0+44.
- **Odd parity count:** send 0x07 → data bits 1,1,1,0,0,0,0,0 and parity bit 1.
- **Back-to-back with data change while busy:**
  - Stimulus: hold `valid_in`=1 with 0x3C then 0xC3. Change `data_in` to 0xFF mid-frame of the first word.
  - First frame transmits 0x3C unchanged.
  - Second accept occurs at E0+45 with the value then on `data_in`.
  - Exactly one idle-high cycle separates the frames.
- **Reset mid-frame:**
  - Stimulus: assert `rst` at E0+20 while sending 0xFF.
  - Next cycle: `tx`=1, `busy`=0, `done` is never asserted.
  - A subsequent 0x01 frame transmits correctly.
- **`PARITY_EN`=0, `CLKS_PER_BIT`=1, `DATA_W`=4:**
  - Stimulus: send 0x9.
  - `tx` sequence is 0,1,0,0,1,1.
  - `done` pulses at E0+6, with F=6.
- **`rst` and `valid_in` at the same edge:** no accept, `busy` stays 0.

Source files
------------

// File: rtl/serial_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_tx
// Brief    : Parallel-to-serial frame transmitter. Accepts a DATA_W-bit word
//            over valid/ready and sends start bit, data LSB-first, optional
//            even parity and stop bit on a registered line. Each bit is held
//            for CLKS_PER_BIT cycles.
// Revision : 1.0 - initial release
// ============================================================================
module serial_frame_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(DATA_W - 1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP   = 3'd4;

    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_shreg;
    logic              r_par;
    logic              r_tx;
    logic              r_busy;
    logic              r_done;

    logic [DATA_W-1:0] w_shifted;
    logic              w_bit_end;

    // Next shift-register contents and end-of-bit-period strobe
    always_comb begin
        w_shifted = r_shreg >> 1;
        w_bit_end = (r_cnt == c_LAST_CNT);
    end

    // Frame sequencer; tx is registered alongside the state so the line value
    // changes on the same edge as the state it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shreg <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (valid_in) begin
                        r_shreg <= data_in;
                        r_par   <= ^data_in;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_state <= c_ST_START;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                c_ST_START: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_state <= c_ST_DATA;
                        r_tx    <= r_shreg[0];
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                c_ST_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_idx == c_LAST_IDX) begin
                            if (PARITY_EN != 0) begin
                                r_state <= c_ST_PARITY;
                                r_tx    <= r_par;
                            end else begin
                                r_state <= c_ST_STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_idx   <= r_idx + IDX_W'(1);
                            r_shreg <= w_shifted;
                            r_tx    <= w_shifted[0];
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                c_ST_PARITY: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_state <= c_ST_STOP;
                        r_tx    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                c_ST_STOP: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_state <= c_ST_IDLE;
                        r_tx    <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ready_out = (r_state == c_ST_IDLE);
    assign tx        = r_tx;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_frame_tx
// Brief    : Bench for serial_frame_tx. Two instances (defaults, and
//            DATA_W=4 / CLKS_PER_BIT=1 / no parity) are compared every cycle
//            against a frame-level model built from bit vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_frame_tx;

    localparam int DW_A = 8, CPB_A = 4, PEN_A = 1;
    localparam int DW_B = 4, CPB_B = 1, PEN_B = 0;
    localparam int FA = (2 + DW_A + PEN_A) * CPB_A;
    localparam int FB = (2 + DW_B + PEN_B) * CPB_B;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [DW_A-1:0] a_data = '0;
    logic            a_valid = 1'b0;
    logic            a_ready, a_tx, a_busy, a_done;
    logic [DW_B-1:0] b_data = '0;
    logic            b_valid = 1'b0;
    logic            b_ready, b_tx, b_busy, b_done;

    int n_checks = 0;
    int n_errors = 0;

    serial_frame_tx #(.DATA_W(DW_A), .CLKS_PER_BIT(CPB_A), .PARITY_EN(PEN_A)) u_dut_a (
        .clk(clk), .rst(rst), .data_in(a_data), .valid_in(a_valid),
        .ready_out(a_ready), .tx(a_tx), .busy(a_busy), .done(a_done)
    );

    serial_frame_tx #(.DATA_W(DW_B), .CLKS_PER_BIT(CPB_B), .PARITY_EN(PEN_B)) u_dut_b (
        .clk(clk), .rst(rst), .data_in(b_data), .valid_in(b_valid),
        .ready_out(b_ready), .tx(b_tx), .busy(b_busy), .done(b_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame as a bit vector, element 0 sent first: start, data LSB-first,
    // optional even parity, stop.
    function automatic logic [63:0] frame_bits(input int dw, input int pen, input logic [31:0] w);
        logic [63:0] fb;
        logic        p;
        fb = '0;
        p  = 1'b0;
        for (int i = 0; i < dw; i++) begin
            fb[1+i] = w[i];
            p       = p ^ w[i];
        end
        if (pen != 0) fb[1+dw] = p;
        fb[1+dw+pen] = 1'b1;
        return fb;
    endfunction

    // Model: after an accept at edge E0, n counts edges since E0. While n < F the
    // line carries bit n/CPB of the frame and busy is high; at n == F done is high.
    bit          model_ok = 0;
    bit          a_act = 0, b_act = 0;
    int          a_n = 0, b_n = 0;
    logic [63:0] a_fb = '0, b_fb = '0;

    // Compare on the falling edge, then advance the model to the next rising edge
    always @(negedge clk) begin
        logic ea_busy, ea_done, ea_tx, eb_busy, eb_done, eb_tx;
        ea_busy = a_act && (a_n < FA);
        ea_done = a_act && (a_n == FA);
        ea_tx   = ea_busy ? a_fb[a_n / CPB_A] : 1'b1;
        eb_busy = b_act && (b_n < FB);
        eb_done = b_act && (b_n == FB);
        eb_tx   = eb_busy ? b_fb[b_n / CPB_B] : 1'b1;
        if (model_ok) begin
            chk("a_tx",    64'(a_tx),    64'(ea_tx));
            chk("a_busy",  64'(a_busy),  64'(ea_busy));
            chk("a_done",  64'(a_done),  64'(ea_done));
            chk("a_ready", 64'(a_ready), 64'(!ea_busy));
            chk("b_tx",    64'(b_tx),    64'(eb_tx));
            chk("b_busy",  64'(b_busy),  64'(eb_busy));
            chk("b_done",  64'(b_done),  64'(eb_done));
            chk("b_ready", 64'(b_ready), 64'(!eb_busy));
        end
        if (rst) begin
            a_act = 0;
            b_act = 0;
            model_ok = 1;
        end else begin
            if (!ea_busy && a_valid) begin
                a_act = 1; a_n = 0; a_fb = frame_bits(DW_A, PEN_A, 32'(a_data));
            end else if (a_act) begin
                if (a_n >= FA) a_act = 0; else a_n++;
            end
            if (!eb_busy && b_valid) begin
                b_act = 1; b_n = 0; b_fb = frame_bits(DW_B, PEN_B, 32'(b_data));
            end else if (b_act) begin
                if (b_n >= FB) b_act = 0; else b_n++;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] lit;

        // Model pinned to hand-derived frames
        chk("model_a5", frame_bits(DW_A, PEN_A, 32'hA5), 64'h54A);
        chk("model_07", frame_bits(DW_A, PEN_A, 32'h07), 64'h60E);
        chk("model_b9", frame_bits(DW_B, PEN_B, 32'h9),  64'h32);

        // Reset values
        #1;
        rst = 1'b1;
        cyc(3);
        chk("rst_tx",    64'(a_tx),    64'd1);
        chk("rst_busy",  64'(a_busy),  64'd0);
        chk("rst_done",  64'(a_done),  64'd0);
        chk("rst_ready", 64'(a_ready), 64'd1);
        rst = 1'b0;
        cyc(2);

        // Single frame 0xA5 with literal line sequence and done timing
        lit = 64'h54A;
        a_data = 8'hA5; a_valid = 1'b1;
        cyc(1);
        a_valid = 1'b0; a_data = 8'h00;
        chk("a5_tx_e0", 64'(a_tx), 64'd0);
        for (int n = 1; n <= FA + 1; n++) begin
            cyc(1);
            if (n < FA) chk("a5_tx_lit", 64'(a_tx), 64'(lit[n / CPB_A]));
            if (n == FA - 1) chk("a5_busy_43", 64'(a_busy), 64'd1);
            if (n == FA) begin
                chk("a5_done_44", 64'(a_done), 64'd1);
                chk("a5_busy_44", 64'(a_busy), 64'd0);
            end
            if (n == FA + 1) chk("a5_done_45", 64'(a_done), 64'd0);
        end
        cyc(2);

        // Odd parity count
        a_data = 8'h07; a_valid = 1'b1;
        cyc(1);
        a_valid = 1'b0;
        cyc(9 * CPB_A);
        chk("p07_parity", 64'(a_tx), 64'd1);
        cyc(FA);

        // Back-to-back, data changed while busy
        a_data = 8'h3C; a_valid = 1'b1;
        cyc(1);
        cyc(10); a_data = 8'hFF;
        cyc(10); a_data = 8'hC3;
        cyc(FA - 20);
        chk("b2b_done",  64'(a_done),  64'd1);
        chk("b2b_ready", 64'(a_ready), 64'd1);
        chk("b2b_idle",  64'(a_tx),    64'd1);
        cyc(1);
        chk("b2b_acc2",  64'(a_busy),  64'd1);
        chk("b2b_start", 64'(a_tx),    64'd0);
        a_valid = 1'b0;
        cyc(FA + 2);

        // Reset mid-frame
        a_data = 8'hFF; a_valid = 1'b1;
        cyc(1);
        a_valid = 1'b0;
        cyc(19);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("mid_rst_tx",   64'(a_tx),   64'd1);
        chk("mid_rst_busy", 64'(a_busy), 64'd0);
        cyc(FA);
        a_data = 8'h01; a_valid = 1'b1;
        cyc(1);
        a_valid = 1'b0;
        cyc(FA + 2);

        // Small instance, no parity, one cycle per bit
        lit = 64'h32;
        b_data = 4'h9; b_valid = 1'b1;
        cyc(1);
        b_valid = 1'b0;
        chk("b9_tx_e0", 64'(b_tx), 64'(lit[0]));
        for (int n = 1; n <= FB; n++) begin
            cyc(1);
            if (n < FB) chk("b9_tx_lit", 64'(b_tx), 64'(lit[n]));
        end
        chk("b9_done_6", 64'(b_done), 64'd1);
        cyc(2);

        // Reset and valid on the same edge
        rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
        cyc(1);
        chk("rv_busy_a", 64'(a_busy), 64'd0);
        chk("rv_busy_b", 64'(b_busy), 64'd0);
        rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        cyc(1);
        chk("rv_busy_a2", 64'(a_busy), 64'd0);

        // Randomized traffic with data churn and occasional resets
        for (int i = 0; i < 4000; i++) begin
            a_valid = ($urandom % 4) != 0;
            a_data  = DW_A'($urandom);
            b_valid = ($urandom % 3) != 0;
            b_data  = DW_B'($urandom);
            rst     = ($urandom % 250) == 0;
            cyc(1);
        end
        rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        cyc(FA + 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
